instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the five-stage pipeline; sits directly upstream of decode and owns the program counter. It issues word reads to the instruction memory controller over a variable-latency request/ready handshake, loads the IF/ID pipeline register (instruction plus next PC), inserts NOP bubbles on memory wait states and honours the execute-stage stall. It also applies the decode-resolved control-flow redirects with MIPS single-delay-slot semantics.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- EXC_VECTOR, 32'h0000_0080, redirect target when id_if_selpctype = 2'b11
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- ex_if_stall  in  1  execute stall; freezes PC and IF/ID
- id_if_selpcsource  in  1  decode requests a redirect for the instruction in ID
- id_if_selpctype  in  2  target select: 00 pcimd2ext, 01 rega, 10 pcindex, 11 EXC_VECTOR
- id_if_rega  in  32  register-jump target
- id_if_pcimd2ext  in  32  branch target
- id_if_pcindex  in  32  jump target
- if_mc_en  out  1  fetch request, held until ready
- if_mc_addr  out  32  fetch word address, stable while if_mc_en = 1
- mc_if_data  in  32  instruction word, valid when mc_if_ready = 1
- mc_if_ready  in  1  request complete this cycle (zero-wait allowed)
- if_id_instruc  out  32  IF/ID instruction register
- if_id_nextpc  out  32  IF/ID register, address of fetched instruction + 4

## Operation
- FSM states: BOOT, REQ, HOLD.
- BOOT: entered on reset; the cycle after reset release goes to REQ with pc = RESET_PC.
- REQ: if_mc_en = 1, if_mc_addr = pc. On mc_if_ready:
  - if ex_if_stall = 0, load IF/ID;
  - otherwise capture mc_if_data into hold_buf and go to HOLD.
- HOLD: if_mc_en = 0. When ex_if_stall = 0, load IF/ID from hold_buf and return to REQ.
- IF/ID load: if_id_instruc <= word, if_id_nextpc <= pc + 4, id_valid <= 1. The pc update is defined under Redirect.
- No completion and ex_if_stall = 0: if_id_instruc <= 32'h0 (NOP), id_valid <= 0, if_id_nextpc holds.
- ex_if_stall = 1: IF/ID, id_valid and pc hold. An in-flight request still completes, into HOLD.
- Redirect: sampled in any cycle with id_valid = 1, ex_if_stall = 0 and id_if_selpcsource = 1. The target is selected by selpctype and bits [1:0] are forced to 00.
  - If a completion occurs in the same cycle, pc <= target directly. That completing word is the delay slot.
  - Otherwise latch redir_pc and set redir_pending. The next completion sets pc <= redir_pc and clears redir_pending.
- PC arithmetic is modulo 2^32; pc + 4 wraps 32'hFFFF_FFFC to 0.
- A second redirect while redir_pending = 1 cannot occur, because ID holds NOP until a completion. If one is seen, the newer target wins.

## Timing
- Reset values:
  - if_mc_en = 0, if_mc_addr = RESET_PC
  - if_id_instruc = 32'h0, if_id_nextpc = 32'h0
  - id_valid = 0, redir_pending = 0, state = BOOT
- First request: if_mc_en = 1 in the first cycle after reset release.
- Throughput: with zero-wait memory, one instruction per cycle. Each wait cycle produces one NOP in IF/ID.
- Latency: a word returned at edge N appears on if_id_instruc after edge N. Decode sees it in cycle N+1.
- if_mc_en and if_mc_addr are functions of state and pc only; there is no combinational path from mc_if_ready.
- Reset asserted mid-request: all state clears immediately and the outstanding read is abandoned. The controller must tolerate an en drop.

## Configuration
- IF_PERF_CNT_EN defined:
  - adds outputs if_perf_fetched (32 bits, increments on each IF/ID load) and if_perf_bubbles (32 bits, increments on each NOP insertion);
  - both reset to 0 and wrap.
- Undefined: these ports and counters do not exist.

## Structure
- Shared package if_pkg holds:
  - the FSM state enum (BOOT, REQ, HOLD);
  - constant IF_NOP = 32'h0;
  - selpctype codes PCT_BRANCH, PCT_REG, PCT_JUMP, PCT_EXC.
- One sub-module, if_pc_target_mux: a combinational target select with alignment masking.

## Test plan
- Reset with RESET_PC = 32'h100 -> outputs at reset values during reset; the cycle after release, if_mc_en = 1 and addr = 32'h100.
- Zero-wait memory returning 0x20080001, 0x20090002 -> consecutive IF/ID loads; nextpc = 0x104, then 0x108; addr = 0x104, then 0x108.
- Ready delayed 3 cycles -> three NOPs in IF/ID and if_mc_addr stable; then the word loads.
- ex_if_stall high for 4 cycles while ready arrives -> state HOLD, if_mc_en = 0, IF/ID frozen; the word loads on the first unstalled edge.
- Branch in ID at 0x200 with selpcsource = 1, selpctype = 00, pcimd2ext = 0x400 -> delay slot 0x204 fetched, next addr 0x400. Repeat with a 2-cycle wait to exercise redir_pending.
- selpctype = 01, rega = 0x333 -> next addr 0x330. Reset mid-wait -> if_mc_en drops asynchronously and the restart fetch goes to RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional build macro IF_PERF_CNT_EN adds fetch/bubble counters to the top.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } if_state_e;

  localparam logic [31:0] IF_NOP = 32'h0000_0000;

  localparam logic [1:0] PCT_BRANCH = 2'b00;
  localparam logic [1:0] PCT_REG    = 2'b01;
  localparam logic [1:0] PCT_JUMP   = 2'b10;
  localparam logic [1:0] PCT_EXC    = 2'b11;

endpackage

// File: rtl/if_pc_target_mux.sv
// Control-flow target select for decode-resolved redirects.
// Targets are forced word aligned.
module if_pc_target_mux
  import if_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic [1:0]  selpctype_i,
  input  logic [31:0] rega_i,
  input  logic [31:0] pcimd2ext_i,
  input  logic [31:0] pcindex_i,
  output logic [31:0] target_o
);

  logic [31:0] raw;

  always_comb begin
    raw = pcimd2ext_i;
    unique case (selpctype_i)
      PCT_BRANCH: raw = pcimd2ext_i;
      PCT_REG:    raw = rega_i;
      PCT_JUMP:   raw = pcindex_i;
      PCT_EXC:    raw = EXC_VECTOR;
      default:    raw = pcimd2ext_i;
    endcase
  end

  assign target_o = {raw[31:2], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches over a ready handshake, loads IF/ID.
// Define IF_PERF_CNT_EN to add if_perf_fetched / if_perf_bubbles.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_if_stall,
  input  logic        id_if_selpcsource,
  input  logic [1:0]  id_if_selpctype,
  input  logic [31:0] id_if_rega,
  input  logic [31:0] id_if_pcimd2ext,
  input  logic [31:0] id_if_pcindex,
  output logic        if_mc_en,
  output logic [31:0] if_mc_addr,
  input  logic [31:0] mc_if_data,
  input  logic        mc_if_ready,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] if_perf_fetched,
  output logic [31:0] if_perf_bubbles,
`endif
  output logic [31:0] if_id_instruc,
  output logic [31:0] if_id_nextpc
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        idv_q, idv_d;
  logic        pend_q, pend_d;
  logic [31:0] rpc_q, rpc_d;

  logic        comp;
  logic        load;
  logic        bubble;
  logic        redir;
  logic [31:0] word;
  logic [31:0] target;

  if_pc_target_mux #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_mux (
    .selpctype_i(id_if_selpctype),
    .rega_i     (id_if_rega),
    .pcimd2ext_i(id_if_pcimd2ext),
    .pcindex_i  (id_if_pcindex),
    .target_o   (target)
  );

  assign comp   = (state_q == REQ) && mc_if_ready;
  assign load   = !ex_if_stall && (comp || (state_q == HOLD));
  assign bubble = !ex_if_stall && !load;
  assign redir  = idv_q && !ex_if_stall && id_if_selpcsource;
  assign word   = (state_q == HOLD) ? hold_q : mc_if_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = REQ;
      REQ:     if (mc_if_ready && ex_if_stall) state_d = HOLD;
      HOLD:    if (!ex_if_stall) state_d = REQ;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    if_mc_en = 1'b0;
    if (state_q == REQ) if_mc_en = 1'b1;
  end

  assign if_mc_addr    = pc_q;
  assign if_id_instruc = instr_q;
  assign if_id_nextpc  = npc_q;

  always_comb begin
    pc_d    = pc_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    idv_d   = idv_q;
    pend_d  = pend_q;
    rpc_d   = rpc_q;
    if (comp && ex_if_stall) hold_d = mc_if_data;
    if (load) begin
      instr_d = word;
      npc_d   = pc_q + 32'd4;
      idv_d   = 1'b1;
      pend_d  = 1'b0;
      // The word loading now is the delay slot of any redirect.
      if (redir)       pc_d = target;
      else if (pend_q) pc_d = rpc_q;
      else             pc_d = pc_q + 32'd4;
    end else if (bubble) begin
      instr_d = IF_NOP;
      idv_d   = 1'b0;
      if (redir) begin
        pend_d = 1'b1;
        rpc_d  = target;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      hold_q  <= IF_NOP;
      instr_q <= IF_NOP;
      npc_q   <= 32'h0;
      idv_q   <= 1'b0;
      pend_q  <= 1'b0;
      rpc_q   <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      idv_q   <= idv_d;
      pend_q  <= pend_d;
      rpc_q   <= rpc_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fet_q, bub_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fet_q <= 32'h0;
      bub_q <= 32'h0;
    end else begin
      if (load)   fet_q <= fet_q + 32'd1;
      if (bubble) bub_q <= bub_q + 32'd1;
    end
  end

  assign if_perf_fetched = fet_q;
  assign if_perf_bubbles = bub_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed per-cycle vectors,
// expected post-edge outputs queued and checked by a monitor.
module tb_instr_fetch_unit;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [31:0] ins;
    logic [31:0] npc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        sel;
  logic [1:0]  ty;
  logic [31:0] rega;
  logic [31:0] imd;
  logic [31:0] idx;
  logic        en;
  logic [31:0] addr;
  logic [31:0] mdata;
  logic        mready;
  logic [31:0] ins;
  logic [31:0] npc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] pf_fet;
  logic [31:0] pf_bub;
`endif

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec = 0;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0100),
    .EXC_VECTOR(32'h0000_0080)
  ) dut (
    .clock            (clk),
    .reset            (rst_n),
    .ex_if_stall      (stall),
    .id_if_selpcsource(sel),
    .id_if_selpctype  (ty),
    .id_if_rega       (rega),
    .id_if_pcimd2ext  (imd),
    .id_if_pcindex    (idx),
    .if_mc_en         (en),
    .if_mc_addr       (addr),
    .mc_if_data       (mdata),
    .mc_if_ready      (mready),
`ifdef IF_PERF_CNT_EN
    .if_perf_fetched  (pf_fet),
    .if_perf_bubbles  (pf_bub),
`endif
    .if_id_instruc    (ins),
    .if_id_nextpc     (npc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("v%0d en", vec), {31'h0, en}, {31'h0, e.en});
        chk($sformatf("v%0d addr", vec), addr, e.addr);
        chk($sformatf("v%0d instruc", vec), ins, e.ins);
        chk($sformatf("v%0d nextpc", vec), npc, e.npc);
        vec++;
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic rdy, input logic [31:0] d,
                      input logic st, input logic s,
                      input logic [1:0] t, input logic [31:0] tgt,
                      input logic xen, input logic [31:0] xaddr,
                      input logic [31:0] xins, input logic [31:0] xnpc);
    exp_t e;
    mready = rdy;
    mdata  = d;
    stall  = st;
    sel    = s;
    ty     = t;
    imd    = (t == 2'b00) ? tgt : 32'h0000_0DE0;
    rega   = (t == 2'b01) ? tgt : 32'h0000_0BE0;
    idx    = (t == 2'b10) ? tgt : 32'h0000_0CE0;
    e.en   = xen;
    e.addr = xaddr;
    e.ins  = xins;
    e.npc  = xnpc;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    stall  = 1'b0;
    sel    = 1'b0;
    ty     = 2'b00;
    rega   = '0;
    imd    = '0;
    idx    = '0;
    mdata  = '0;
    mready = 1'b0;
    #12;
    chk("rst en", {31'h0, en}, 32'h0);
    chk("rst addr", addr, 32'h100);
    chk("rst instruc", ins, 32'h0);
    chk("rst nextpc", npc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // boot, then zero-wait fetches
    step(0, 32'h0, 0, 0, 2'b00, 0, 1, 32'h100, 32'h0, 32'h0);
    step(1, 32'h2008_0001, 0, 0, 2'b00, 0, 1, 32'h104, 32'h2008_0001, 32'h104);
    step(1, 32'h2009_0002, 0, 0, 2'b00, 0, 1, 32'h108, 32'h2009_0002, 32'h108);
    // three wait cycles
    step(0, 32'h0, 0, 0, 2'b00, 0, 1, 32'h108, 32'h0, 32'h108);
    step(0, 32'h0, 0, 0, 2'b00, 0, 1, 32'h108, 32'h0, 32'h108);
    step(0, 32'h0, 0, 0, 2'b00, 0, 1, 32'h108, 32'h0, 32'h108);
    step(1, 32'h2010_0003, 0, 0, 2'b00, 0, 1, 32'h10C, 32'h2010_0003, 32'h10C);
    // stall while ready arrives: HOLD for 4 cycles
    step(1, 32'h2011_0004, 1, 0, 2'b00, 0, 0, 32'h10C, 32'h2010_0003, 32'h10C);
    step(0, 32'h0, 1, 0, 2'b00, 0, 0, 32'h10C, 32'h2010_0003, 32'h10C);
    step(0, 32'h0, 1, 0, 2'b00, 0, 0, 32'h10C, 32'h2010_0003, 32'h10C);
    step(0, 32'h0, 1, 0, 2'b00, 0, 0, 32'h10C, 32'h2010_0003, 32'h10C);
    step(0, 32'h0, 0, 0, 2'b00, 0, 1, 32'h110, 32'h2011_0004, 32'h110);
    // jump to 0x1FC, delay slot 0x110
    step(1, 32'h0000_0111, 0, 1, 2'b10, 32'h1FC, 1, 32'h1FC, 32'h0000_0111, 32'h114);
    step(1, 32'h0000_01FC, 0, 0, 2'b00, 0, 1, 32'h200, 32'h0000_01FC, 32'h200);
    step(1, 32'h1000_00FF, 0, 0, 2'b00, 0, 1, 32'h204, 32'h1000_00FF, 32'h204);
    // branch at 0x200 -> 0x400, delay slot 0x204
    step(1, 32'h0000_0204, 0, 1, 2'b00, 32'h400, 1, 32'h400, 32'h0000_0204, 32'h208);
    step(1, 32'h0000_0400, 0, 0, 2'b00, 0, 1, 32'h404, 32'h0000_0400, 32'h404);
    // branch with 2-cycle wait, misaligned target 0x602 -> 0x600
    step(0, 32'h0, 0, 1, 2'b00, 32'h602, 1, 32'h404, 32'h0, 32'h404);
    step(0, 32'h0, 0, 0, 2'b00, 0, 1, 32'h404, 32'h0, 32'h404);
    step(1, 32'h0000_0404, 0, 0, 2'b00, 0, 1, 32'h600, 32'h0000_0404, 32'h408);
    step(1, 32'h0000_0600, 0, 0, 2'b00, 0, 1, 32'h604, 32'h0000_0600, 32'h604);
    // register jump 0x333 -> 0x330
    step(1, 32'h0000_0604, 0, 1, 2'b01, 32'h333, 1, 32'h330, 32'h0000_0604, 32'h608);
    step(1, 32'h0000_0330, 0, 0, 2'b00, 0, 1, 32'h334, 32'h0000_0330, 32'h334);
    // exception vector
    step(1, 32'h0000_0334, 0, 1, 2'b11, 0, 1, 32'h080, 32'h0000_0334, 32'h338);
    step(0, 32'h0, 0, 0, 2'b00, 0, 1, 32'h080, 32'h0, 32'h338);
    drain();
    // reset mid-wait: en drops asynchronously
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst en", {31'h0, en}, 32'h0);
    chk("midrst addr", addr, 32'h100);
    chk("midrst instruc", ins, 32'h0);
    chk("midrst nextpc", npc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 32'h0, 0, 0, 2'b00, 0, 1, 32'h100, 32'h0, 32'h0);
    step(1, 32'hCAFE_0001, 0, 0, 2'b00, 0, 1, 32'h104, 32'hCAFE_0001, 32'h104);
    // jump to top of memory, pc wraps to 0
    step(1, 32'h0000_0104, 0, 1, 2'b10, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0104, 32'h108);
    step(1, 32'hFFFF_FFFC, 0, 0, 2'b00, 0, 1, 32'h0, 32'hFFFF_FFFC, 32'h0);
    step(1, 32'h0000_0000, 0, 0, 2'b00, 0, 1, 32'h4, 32'h0000_0000, 32'h4);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
